instruction_fetch_buffer: RTL and testbench

- Fetch stage directly upstream of the decode/execute pipeline register.
- Generates sequential PCs and issues requests to instruction memory over a valid/ready request channel with in-order, variable-latency responses.
- Buffers returned words with their PCs in a DEPTH-entry FIFO and presents them to decode over a valid/ready handshake.
- A branch redirect from execute flushes the buffer and all in-flight fetches, then restarts at the target.

---
 rtl/instruction_fetch_buffer.sv | 110 +++++++++++
 tb/tb_instruction_fetch_buffer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_buffer.sv
// Fetch stage: sequential PC generation, in-order imem requests, DEPTH-entry instruction FIFO to decode.
// Optional FETCH_BYPASS_EN: empty-FIFO responses go straight to decode in the same cycle.
module instruction_fetch_buffer #(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    output logic              out_valid,
    output logic [31:0]       out_instruction,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              out_ready
);
    // valid/ready: a transfer happens on a rising edge where both are high; the
    // producer holds valid and payload stable until the transfer completes.
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] pend_pc [DEPTH];
    logic [PW-1:0]     pend_rd, pend_wr;
    logic [ADDR_W-1:0] fifo_pc [DEPTH];
    logic [31:0]       fifo_data [DEPTH];
    logic [PW-1:0]     fifo_rd, fifo_wr;
    logic [CW-1:0]     fifo_count, outstanding, drop;

    logic [CW:0] in_use;
    logic req_fire, rsp_fire, rsp_keep, bypass, out_fire, fifo_push, fifo_pop;

    always_comb begin
        in_use         = {1'b0, fifo_count} + {1'b0, outstanding};
        // Space is reserved at request time, so the FIFO can never overflow.
        imem_req_valid = reset && !redirect_valid && (in_use < DEPTH_L);
        imem_req_addr  = fetch_pc;
        req_fire       = imem_req_valid && imem_req_ready;
        rsp_fire       = reset && imem_rsp_valid && (outstanding != '0);
        rsp_keep       = rsp_fire && (drop == '0) && !redirect_valid;
`ifdef FETCH_BYPASS_EN
        bypass         = rsp_keep && (fifo_count == '0);
`else
        bypass         = 1'b0;
`endif
        out_valid       = 1'b0;
        out_instruction = NOP;
        out_pc          = '0;
        if (fifo_count != '0) begin
            out_valid       = 1'b1;
            out_instruction = fifo_data[fifo_rd];
            out_pc          = fifo_pc[fifo_rd];
        end else if (bypass) begin
            out_valid       = 1'b1;
            out_instruction = imem_rsp_data;
            out_pc          = pend_pc[pend_rd];
        end
        out_fire  = out_valid && out_ready;
        fifo_pop  = out_fire && (fifo_count != '0);
        fifo_push = rsp_keep && !(bypass && out_ready);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            pend_rd     <= '0;
            pend_wr     <= '0;
            fifo_rd     <= '0;
            fifo_wr     <= '0;
            fifo_count  <= '0;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            if (rsp_fire) pend_rd <= pend_rd + PW'(1);
            if (req_fire) pend_wr <= pend_wr + PW'(1);
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_fire);
            if (redirect_valid) begin
                // Everything still in flight belongs to the wrong path; a response
                // arriving this cycle is discarded here rather than counted.
                fetch_pc   <= {redirect_pc[ADDR_W-1:2], 2'b00};
                fifo_rd    <= '0;
                fifo_wr    <= '0;
                fifo_count <= '0;
                drop       <= outstanding - CW'(rsp_fire);
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + ADDR_W'(4);
                if (rsp_fire && (drop != '0)) drop <= drop - CW'(1);
                if (fifo_push) fifo_wr <= fifo_wr + PW'(1);
                if (fifo_pop)  fifo_rd <= fifo_rd + PW'(1);
                fifo_count <= fifo_count + CW'(fifo_push) - CW'(fifo_pop);
            end
        end
    end

    // Storage arrays carry no reset; every write is already qualified by reset.
    always_ff @(posedge clock) begin
        if (req_fire) pend_pc[pend_wr] <= fetch_pc;
        if (fifo_push) begin
            fifo_pc[fifo_wr]   <= pend_pc[pend_rd];
            fifo_data[fifo_wr] <= imem_rsp_data;
        end
    end
endmodule

// File: tb/tb_instruction_fetch_buffer.sv
// Randomized bench for instruction_fetch_buffer: the bench plays instruction memory and
// predicts decode output by tagging each fetch with the redirect epoch it was issued in.
module tb_instruction_fetch_buffer;
    localparam int          DEPTH    = 4;
    localparam int          ADDR_W   = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              redirect_valid = 1'b0;
    logic [ADDR_W-1:0] redirect_pc = '0;
    logic              imem_req_valid;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_req_ready = 1'b0;
    logic              imem_rsp_valid = 1'b0;
    logic [31:0]       imem_rsp_data = '0;
    logic              out_valid;
    logic [31:0]       out_instruction;
    logic [ADDR_W-1:0] out_pc;
    logic              out_ready = 1'b0;

    instruction_fetch_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
        .clock(clock), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .out_valid(out_valid), .out_instruction(out_instruction), .out_pc(out_pc),
        .out_ready(out_ready)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } pend_t;

    logic [63:0] exp_q[$];
    pend_t       pend[$];
    logic [31:0] m_pc = RESET_PC;
    int          epoch = 0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    int          p_out = 100, p_req = 100, p_redir = 0, lat_min = 1, lat_max = 1;
    bit          spur_en = 1'b0;
    bit          force_redir = 1'b0;
    logic [31:0] force_pc = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_0013;
    endfunction

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            reset          = 1'b0;
            redirect_valid = 1'b0;
            imem_req_ready = 1'($urandom_range(1));
            out_ready      = 1'($urandom_range(1));
            imem_rsp_valid = 1'($urandom_range(1));
            imem_rsp_data  = $urandom;
            #1;
            check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
            if (i > 0) begin
                check("rst_out_valid", {31'b0, out_valid}, 32'd0);
                check("rst_out_instr", out_instruction, 32'h0000_0013);
                check("rst_out_pc", out_pc, 32'd0);
            end
            @(posedge clock);
            cyc++;
        end
        exp_q.delete();
        pend.delete();
        m_pc = RESET_PC;
        epoch++;
    endtask

    task automatic run_cycles(input int n);
        bit    rsp_acc, rsp_live, byp, exp_room, exp_ov, req_fire, out_fire;
        pend_t ent;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            reset          = 1'b1;
            out_ready      = ($urandom_range(99) < p_out);
            imem_req_ready = ($urandom_range(99) < p_req);
            redirect_valid = ($urandom_range(999) < p_redir);
            redirect_pc    = $urandom;
            if (force_redir) begin
                redirect_valid = 1'b1;
                redirect_pc    = force_pc;
                force_redir    = 1'b0;
            end
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(pend[0].addr);
            end else begin
                imem_rsp_valid = spur_en && (pend.size() == 0) && ($urandom_range(9) == 0);
                imem_rsp_data  = $urandom;
            end
            #1;
            rsp_acc  = imem_rsp_valid && (pend.size() > 0);
            rsp_live = rsp_acc && (pend[0].epoch == epoch) && !redirect_valid;
            exp_room = (exp_q.size() + pend.size() < DEPTH) && !redirect_valid;
            byp = 1'b0;
`ifdef FETCH_BYPASS_EN
            byp = rsp_live && (exp_q.size() == 0);
`endif
            exp_ov = (exp_q.size() > 0) || byp;
            check("out_valid", {31'b0, out_valid}, {31'b0, exp_ov});
            if (exp_q.size() > 0) begin
                check("out_pc", out_pc, exp_q[0][63:32]);
                check("out_instruction", out_instruction, exp_q[0][31:0]);
            end else if (byp) begin
                check("byp_pc", out_pc, pend[0].addr);
                check("byp_instruction", out_instruction, mem_word(pend[0].addr));
            end
            check("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_room});
            if (exp_room) check("req_addr", imem_req_addr, m_pc);
            req_fire = exp_room && imem_req_ready;
            out_fire = exp_ov && out_ready;
            @(posedge clock);
            cyc++;
            if (out_fire && exp_q.size() > 0) void'(exp_q.pop_front());
            if (rsp_acc) begin
                ent = pend.pop_front();
                if (rsp_live && !(byp && out_fire))
                    exp_q.push_back({ent.addr, mem_word(ent.addr)});
            end
            if (redirect_valid) begin
                exp_q.delete();
                epoch++;
                m_pc = {redirect_pc[31:2], 2'b00};
            end else if (req_fire) begin
                pend.push_back('{m_pc, epoch, cyc + $urandom_range(lat_max, lat_min) - 1});
                m_pc += 32'd4;
            end
        end
    endtask

    initial begin
        do_reset(3);
        // Streaming at full rate with a single-cycle memory.
        run_cycles(30);
        // Decode stall: the buffer fills and requests stop; then drain.
        p_out = 0;
        run_cycles(10);
        p_out = 100;
        run_cycles(10);
        // Slow memory with fetches in flight, then a misaligned redirect target.
        lat_min = 3; lat_max = 3;
        run_cycles(6);
        force_redir = 1'b1; force_pc = 32'h0000_0103;
        run_cycles(12);
        // Address wrap past the top of memory.
        force_redir = 1'b1; force_pc = 32'hFFFF_FFF8;
        run_cycles(10);
        // Back-to-back redirects.
        run_cycles(3);
        force_redir = 1'b1; force_pc = 32'h0000_2000;
        run_cycles(1);
        force_redir = 1'b1; force_pc = 32'h0000_3004;
        run_cycles(12);
        // Random traffic with redirects, stalls, variable latency and stray responses.
        p_out = 70; p_req = 70; p_redir = 20; lat_min = 1; lat_max = 4; spur_en = 1'b1;
        run_cycles(2000);
        // Reset in the middle of operation with words buffered and fetches in flight.
        p_out = 0; p_req = 100; p_redir = 0; lat_min = 4; lat_max = 6; spur_en = 1'b0;
        run_cycles(5);
        do_reset(2);
        p_out = 100; lat_min = 1; lat_max = 2;
        run_cycles(30);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
